// File: rtl/sat_packer_if.sv
// Stream bundle for sat_packer: filtered sample input plus the packed-word
// ready/valid output toward the bus/DMA writer.
interface sat_packer_if #(
    parameter int DATA_W = 4,
    parameter int PACK_N = 4
);
    localparam int CW = $clog2(PACK_N + 1);

    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ovf;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W*PACK_N-1:0]   out_data;
    logic [PACK_N-1:0]          out_ovf_mask;
    logic [CW-1:0]              out_count;

    modport slave (
        input  in_valid, in_data, in_ovf, flush, out_ready,
        output out_valid, out_data, out_ovf_mask, out_count
    );

    modport master (
        output in_valid, in_data, in_ovf, flush, out_ready,
        input  out_valid, out_data, out_ovf_mask, out_count
    );
endinterface

// File: rtl/sat_packer.sv
// Packs PACK_N filtered samples (plus per-lane overflow flags) into wide words,
// buffers them in a small FIFO and drops input samples when no room is left.
module sat_packer #(
    parameter int DATA_W     = 4,
    parameter int PACK_N     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sat_packer_if.slave      bus,
    output logic             full,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int KW = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int CW = $clog2(PACK_N + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = DATA_W * PACK_N;
    localparam logic [CW-1:0] C_PACK  = CW'(PACK_N);
    localparam logic [AW:0]   C_DEPTH = (AW + 1)'(FIFO_DEPTH);

    logic [WW-1:0]     r_asm_data;
    logic [PACK_N-1:0] r_asm_mask;
    logic [KW-1:0]     r_k;

    logic [WW-1:0]     r_mem_data [FIFO_DEPTH];
    logic [PACK_N-1:0] r_mem_mask [FIFO_DEPTH];
    logic [CW-1:0]     r_mem_cnt  [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [CNT_W-1:0]  r_ovf_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [CW-1:0]     w_sum;
    logic [WW-1:0]     w_word_data;
    logic [PACK_N-1:0] w_word_mask;
    logic              w_pop;
    logic              w_push_req;
    logic              w_room;
    logic              w_push;
    logic              w_blocked;
    logic              w_accept;

    // The candidate word already includes this cycle's sample in lane k.
    always_comb begin
        w_word_data = r_asm_data;
        w_word_mask = r_asm_mask;
        for (int i = 0; i < PACK_N; i++) begin
            if (bus.in_valid && (r_k == KW'(i))) begin
                w_word_data[i*DATA_W +: DATA_W] = bus.in_data;
                w_word_mask[i]                  = bus.in_ovf;
            end else begin
                w_word_data[i*DATA_W +: DATA_W] = r_asm_data[i*DATA_W +: DATA_W];
                w_word_mask[i]                  = r_asm_mask[i];
            end
        end
    end

    // Push/pop decision; a blocked push freezes assembly and drops the sample.
    always_comb begin
        w_sum      = CW'(r_k) + CW'(bus.in_valid);
        w_pop      = (r_count != {(AW + 1){1'b0}}) && bus.out_ready;
        w_push_req = (w_sum == C_PACK) || (bus.flush && (w_sum != {CW{1'b0}}));
        w_room     = (r_count != C_DEPTH) || w_pop;
        w_push     = w_push_req && w_room;
        w_blocked  = w_push_req && !w_room;
        w_accept   = bus.in_valid && !w_blocked;
    end

    // Assembly register and lane counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asm_data <= {WW{1'b0}};
            r_asm_mask <= {PACK_N{1'b0}};
            r_k        <= {KW{1'b0}};
        end else if (w_push) begin
            r_asm_data <= {WW{1'b0}};
            r_asm_mask <= {PACK_N{1'b0}};
            r_k        <= {KW{1'b0}};
        end else if (w_accept) begin
            r_asm_data <= w_word_data;
            r_asm_mask <= w_word_mask;
            r_k        <= r_k + KW'(1'b1);
        end else begin
            r_asm_data <= r_asm_data;
            r_asm_mask <= r_asm_mask;
            r_k        <= r_k;
        end
    end

    // Packed-word FIFO; storage is cleared on reset so outputs read zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= {WW{1'b0}};
                r_mem_mask[i] <= {PACK_N{1'b0}};
                r_mem_cnt[i]  <= {CW{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_word_data;
                r_mem_mask[r_wr_ptr] <= w_word_mask;
                r_mem_cnt[r_wr_ptr]  <= w_sum;
                r_wr_ptr             <= r_wr_ptr + AW'(1'b1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1'b1);
                2'b01:   r_count <= r_count - (AW + 1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt  <= {CNT_W{1'b0}};
            r_drop_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_accept && bus.in_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1'b1);
            end else begin
                r_ovf_cnt <= r_ovf_cnt;
            end
            if (bus.in_valid && w_blocked && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1'b1);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign bus.out_valid    = (r_count != {(AW + 1){1'b0}});
    assign bus.out_data     = r_mem_data[r_rd_ptr];
    assign bus.out_ovf_mask = r_mem_mask[r_rd_ptr];
    assign bus.out_count    = r_mem_cnt[r_rd_ptr];
    assign full             = (r_count == C_DEPTH);
    assign ovf_cnt          = r_ovf_cnt;
    assign drop_cnt         = r_drop_cnt;
endmodule
